c64_mem_bus: RTL and testbench

- Memory/bus stage directly downstream of the 6502 core; consumes the core's ab/do/we and returns its di.
- Holds 64 KB RAM and the processor port registers ($00 DDR, $01 PORT).
- Decodes LORAM/HIRAM/CHAREN banking to steer accesses to RAM, external ROM or external I/O.
- Contains a byte-stream loader FSM that preloads RAM while holding the CPU in reset.

---
 rtl/c64_mem_bus_if.sv | 31 +++
 rtl/c64_mem_bus.sv | 98 +++++++++
 tb/tb_c64_mem_bus.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/c64_mem_bus_if.sv
// c64_mem_bus_if: CPU, ROM, I/O and loader signals of the C64 memory stage
interface c64_mem_bus_if;
  logic [15:0] ab;
  logic [7:0] cpu_do;
  logic we;
  logic [7:0] cpu_di;
  logic cpu_reset;
  logic [1:0] rom_sel;
  logic [12:0] rom_addr;
  logic [7:0] rom_data;
  logic io_cs;
  logic io_we;
  logic [11:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic ld_start;
  logic [15:0] ld_addr;
  logic [15:0] ld_len;
  logic ld_valid;
  logic [7:0] ld_data;
  logic ld_ready;
  logic ld_busy;
  modport master (
    output ab, cpu_do, we, rom_data, io_rdata, ld_start, ld_addr, ld_len, ld_valid, ld_data,
    input cpu_di, cpu_reset, rom_sel, rom_addr, io_cs, io_we, io_addr, io_wdata, ld_ready, ld_busy
  );
  modport slave (
    input ab, cpu_do, we, rom_data, io_rdata, ld_start, ld_addr, ld_len, ld_valid, ld_data,
    output cpu_di, cpu_reset, rom_sel, rom_addr, io_cs, io_we, io_addr, io_wdata, ld_ready, ld_busy
  );
endinterface

// File: rtl/c64_mem_bus.sv
// c64_mem_bus: 64 KB RAM, processor port, bank decode and RAM preloader for a 6502 core
module c64_mem_bus #(
  parameter int RAM_AW = 16,
  parameter int RESET_HOLD = 2
) (
  input logic clk,
  input logic reset,
  c64_mem_bus_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  localparam logic [7:0] RH = 8'(RESET_HOLD);
  state_t state, state_n;
  logic pend;
  logic [7:0] cnt, cnt_n;
  logic [15:0] la, la_n, ll, ll_n;
  logic [7:0] ram [2**RAM_AW];
  logic [7:0] ddr, port;
  logic [2:0] eff;
  logic loram, hiram, charen, in_d, basic, chr, kernal, cpu_wr, ld_wr;
  // undriven port pins read as pulled-up ones
  assign eff = port[2:0] | ~ddr[2:0];
  assign loram = eff[0];
  assign hiram = eff[1];
  assign charen = eff[2];
  assign in_d = bus.ab[15:12] == 4'hD;
  assign basic = bus.ab[15:13] == 3'b101 && loram && hiram;
  assign chr = in_d && (loram || hiram) && !charen;
  assign kernal = bus.ab[15:13] == 3'b111 && hiram;
  assign bus.io_cs = in_d && (loram || hiram) && charen;
  assign bus.rom_sel = basic ? 2'd0 : chr ? 2'd1 : kernal ? 2'd2 : 2'd3;
  assign bus.rom_addr = bus.ab[12:0];
  assign bus.io_addr = bus.ab[11:0];
  assign bus.io_wdata = bus.cpu_do;
  assign bus.cpu_reset = pend || state != IDLE;
  assign bus.ld_ready = state == LOAD;
  assign bus.ld_busy = state != IDLE;
  assign cpu_wr = bus.we && !bus.cpu_reset && !reset;
  assign ld_wr = state == LOAD && bus.ld_valid && !reset;
  assign bus.io_we = bus.io_cs && cpu_wr;
  assign bus.cpu_di = bus.ab == 16'h0000 ? ddr :
                      bus.ab == 16'h0001 ? (port & ddr) | ~ddr :
                      bus.io_cs ? bus.io_rdata :
                      bus.rom_sel != 2'd3 ? bus.rom_data : ram[bus.ab[RAM_AW-1:0]];
  // pend covers the first cycle after reset so the hold lasts exactly RESET_HOLD cycles
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    la_n = la;
    ll_n = ll;
    if (pend) begin
      state_n = cnt <= 8'd1 ? IDLE : HOLD;
      cnt_n = cnt - 8'd1;
    end else begin
      case (state)
        IDLE: if (bus.ld_start) begin
          la_n = bus.ld_addr;
          ll_n = bus.ld_len;
          state_n = bus.ld_len == 16'd0 ? HOLD : LOAD;
          cnt_n = RH;
        end
        LOAD: if (ld_wr) begin
          la_n = la + 16'd1;
          ll_n = ll - 16'd1;
          state_n = ll == 16'd1 ? HOLD : LOAD;
          cnt_n = RH;
        end
        HOLD: begin
          state_n = cnt <= 8'd1 ? IDLE : HOLD;
          cnt_n = cnt - 8'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend <= 1'b1;
      cnt <= RH;
      la <= '0;
      ll <= '0;
      ddr <= '0;
      port <= '0;
    end else begin
      state <= state_n;
      pend <= 1'b0;
      cnt <= cnt_n;
      la <= la_n;
      ll <= ll_n;
      if (cpu_wr && bus.ab == 16'h0000) ddr <= bus.cpu_do;
      if (cpu_wr && bus.ab == 16'h0001) port <= bus.cpu_do;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_wr) ram[la[RAM_AW-1:0]] <= bus.ld_data;
    else if (cpu_wr && !bus.io_cs) ram[bus.ab[RAM_AW-1:0]] <= bus.cpu_do;
  end
endmodule

// File: tb/tb_c64_mem_bus.sv
// tb_c64_mem_bus: directed scenario tests for the C64 memory/bus stage
module tb_c64_mem_bus;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int failures = 0;
  c64_mem_bus_if b();
  c64_mem_bus dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  assign b.rom_data = 8'hB0 | {6'd0, b.rom_sel};
  assign b.io_rdata = 8'hC5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    b.ab = a;
    b.cpu_do = d;
    b.we = 1;
    tick();
    b.we = 0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] e);
    b.ab = a;
    #1;
    checks++;
    if (b.cpu_di !== e) begin
      failures++;
      $display("FAIL %s read %h got=%h exp=%h", name, a, b.cpu_di, e);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    checks++;
    if (b.cpu_reset !== 1'b1 || b.ld_busy !== 1'b0 || b.ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rst=%b busy=%b rdy=%b exp 1 0 0", b.cpu_reset, b.ld_busy, b.ld_ready);
    end
    reset = 0;
    #1;
    checks++;
    if (b.cpu_reset !== 1'b1) begin failures++; $display("FAIL hold_c1 got=%b exp=1", b.cpu_reset); end
    tick();
    checks++;
    if (b.cpu_reset !== 1'b1) begin failures++; $display("FAIL hold_c2 got=%b exp=1", b.cpu_reset); end
    tick();
    checks++;
    if (b.cpu_reset !== 1'b0 || b.ld_busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_end got rst=%b busy=%b exp 0 0", b.cpu_reset, b.ld_busy);
    end
    rd("port_reset", 16'h0001, 8'hFF);
    rd("ddr_reset", 16'h0000, 8'h00);
    rd("kernal_reset", 16'hE000, 8'hB2);
    checks++;
    if (b.rom_sel !== 2'd2) begin failures++; $display("FAIL kernal_sel got=%0d exp=2", b.rom_sel); end
  endtask

  task automatic test_load();
    b.ld_start = 1;
    b.ld_addr = 16'hC000;
    b.ld_len = 16'd3;
    tick();
    b.ld_start = 0;
    checks++;
    if (b.ld_busy !== 1'b1 || b.ld_ready !== 1'b1 || b.cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL load_enter got busy=%b rdy=%b rst=%b exp 1 1 1", b.ld_busy, b.ld_ready, b.cpu_reset);
    end
    b.ld_valid = 1; b.ld_data = 8'h11; tick();
    b.ld_valid = 0; tick();
    b.ld_valid = 1; b.ld_data = 8'h22; tick();
    b.ld_data = 8'h33; tick();
    b.ld_valid = 0;
    checks++;
    if (b.ld_busy !== 1'b1 || b.ld_ready !== 1'b0 || b.cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL load_hold got busy=%b rdy=%b rst=%b exp 1 0 1", b.ld_busy, b.ld_ready, b.cpu_reset);
    end
    tick();
    checks++;
    if (b.ld_busy !== 1'b1 || b.cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL load_hold2 got busy=%b rst=%b exp 1 1", b.ld_busy, b.cpu_reset);
    end
    tick();
    checks++;
    if (b.ld_busy !== 1'b0 || b.cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL load_done got busy=%b rst=%b exp 0 0", b.ld_busy, b.cpu_reset);
    end
    rd("load_b0", 16'hC000, 8'h11);
    rd("load_b1", 16'hC001, 8'h22);
    rd("load_b2", 16'hC002, 8'h33);
  endtask

  task automatic test_banking();
    cpu_write(16'h0000, 8'h07);
    cpu_write(16'h0001, 8'h05);
    rd("ddr_rd", 16'h0000, 8'h07);
    rd("port_rd", 16'h0001, 8'hFD);
    b.ab = 16'hE000;
    #1;
    checks++;
    if (b.rom_sel !== 2'd3) begin failures++; $display("FAIL e000_ram_sel got=%0d exp=3", b.rom_sel); end
    b.ab = 16'hA000;
    #1;
    checks++;
    if (b.rom_sel !== 2'd3) begin failures++; $display("FAIL a000_ram_sel got=%0d exp=3", b.rom_sel); end
    cpu_write(16'hE000, 8'h5A);
    rd("e000_ram", 16'hE000, 8'h5A);
    cpu_write(16'h0001, 8'h07);
    rd("e000_kernal", 16'hE000, 8'hB2);
    rd("a000_basic", 16'hA000, 8'hB0);
  endtask

  task automatic test_io();
    cpu_write(16'h0001, 8'h00);
    cpu_write(16'hD020, 8'h33);
    rd("d020_ram", 16'hD020, 8'h33);
    cpu_write(16'h0001, 8'h07);
    b.ab = 16'hD020;
    b.cpu_do = 8'h0E;
    b.we = 1;
    #1;
    checks++;
    if (b.io_cs !== 1'b1 || b.io_we !== 1'b1 || b.io_addr !== 12'h020 || b.io_wdata !== 8'h0E || b.cpu_di !== 8'hC5) begin
      failures++;
      $display("FAIL io_write got cs=%b we=%b addr=%h wd=%h di=%h exp 1 1 020 0e c5",
               b.io_cs, b.io_we, b.io_addr, b.io_wdata, b.cpu_di);
    end
    tick();
    b.we = 0;
    cpu_write(16'h0001, 8'h00);
    rd("d020_unchanged", 16'hD020, 8'h33);
    cpu_write(16'h0001, 8'h03);
    rd("d020_char", 16'hD020, 8'hB1);
    checks++;
    if (b.rom_sel !== 2'd1 || b.io_cs !== 1'b0) begin
      failures++;
      $display("FAIL char_sel got sel=%0d cs=%b exp 1 0", b.rom_sel, b.io_cs);
    end
    cpu_write(16'h0001, 8'h07);
  endtask

  task automatic test_back_to_back();
    b.ld_start = 1; b.ld_addr = 16'hFFFF; b.ld_len = 16'd2; tick();
    b.ld_addr = 16'h2000; b.ld_len = 16'd5; tick();
    b.ld_start = 0;
    b.ld_valid = 1; b.ld_data = 8'hAA; tick();
    b.ld_data = 8'hBB; tick();
    b.ld_valid = 0;
    tick();
    tick();
    checks++;
    if (b.ld_busy !== 1'b0) begin failures++; $display("FAIL wrap_done got busy=%b exp=0", b.ld_busy); end
    cpu_write(16'h0001, 8'h05);
    rd("wrap_ffff", 16'hFFFF, 8'hAA);
    checks++;
    if (dut.ram[0] !== 8'hBB) begin failures++; $display("FAIL wrap_0000 got=%h exp=bb", dut.ram[0]); end
    cpu_write(16'h0001, 8'h07);
    cpu_write(16'h3000, 8'h44);
    b.ld_start = 1; b.ld_addr = 16'h3000; b.ld_len = 16'd0;
    b.ld_valid = 1; b.ld_data = 8'h77;
    tick();
    b.ld_start = 0;
    checks++;
    if (b.ld_busy !== 1'b1 || b.ld_ready !== 1'b0 || b.cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL len0_hold got busy=%b rdy=%b rst=%b exp 1 0 1", b.ld_busy, b.ld_ready, b.cpu_reset);
    end
    tick();
    checks++;
    if (b.ld_busy !== 1'b1) begin failures++; $display("FAIL len0_hold2 got busy=%b exp=1", b.ld_busy); end
    tick();
    b.ld_valid = 0;
    checks++;
    if (b.ld_busy !== 1'b0 || b.cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL len0_done got busy=%b rst=%b exp 0 0", b.ld_busy, b.cpu_reset);
    end
    rd("len0_nowrite", 16'h3000, 8'h44);
  endtask

  task automatic test_abort();
    cpu_write(16'h5001, 8'hEE);
    b.ld_start = 1; b.ld_addr = 16'h5000; b.ld_len = 16'd4; tick();
    b.ld_start = 0;
    b.ld_valid = 1; b.ld_data = 8'h9A; tick();
    reset = 1;
    b.ld_start = 1; b.ld_addr = 16'h6000; b.ld_len = 16'd1;
    b.ld_data = 8'h9B;
    tick();
    checks++;
    if (b.ld_busy !== 1'b0 || b.ld_ready !== 1'b0 || b.cpu_reset !== 1'b1) begin
      failures++;
      $display("FAIL abort_state got busy=%b rdy=%b rst=%b exp 0 0 1", b.ld_busy, b.ld_ready, b.cpu_reset);
    end
    reset = 0;
    b.ld_start = 0;
    b.ld_valid = 0;
    tick();
    checks++;
    if (b.cpu_reset !== 1'b1) begin failures++; $display("FAIL abort_hold got=%b exp=1", b.cpu_reset); end
    tick();
    checks++;
    if (b.cpu_reset !== 1'b0 || b.ld_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_done got rst=%b busy=%b exp 0 0", b.cpu_reset, b.ld_busy);
    end
    rd("abort_kept", 16'h5000, 8'h9A);
    rd("abort_next", 16'h5001, 8'hEE);
    rd("abort_ddr", 16'h0000, 8'h00);
  endtask

  initial begin
    reset = 1;
    b.ab = 0; b.cpu_do = 0; b.we = 0;
    b.ld_start = 0; b.ld_addr = 0; b.ld_len = 0; b.ld_valid = 0; b.ld_data = 0;
    test_reset();
    test_load();
    test_banking();
    test_io();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
